seq_stage_ctrl: RTL
===================

# seq_stage_ctrl

Phase sequencer and PC-update controller for the sequential Y86-64 core. It walks each instruction through Fetch, Decode, Execute, Memory, Write-back and PC-update, and issues one enable strobe per phase to the stage blocks. It owns the architectural PC, which feeds `fetch`, and selects the next PC from valP, valC or valM. It also derives the 2-bit processor status from fetch and data-memory errors, and stops the core on halt or fault.

## Interface
- `RESET_PC`, default 64'h0, PC value loaded on reset.
- `MEM_TIMEOUT`, default 15, maximum wait cycles in MEMORY before an ADR fault (1..255).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  leave IDLE and begin fetching at the current PC.
- `icode`  in  4  instruction code from fetch.
- `instr_valid`  in  1  fetch decoded a legal instruction.
- `imem_error`  in  1  fetch address out of range.
- `cnd`  in  1  condition result from execute.
- `valC`  in  64  constant or target from fetch.
- `valP`  in  64  fall-through PC from fetch.
- `valM`  in  64  data read from memory (return address for `ret`).
- `mem_ready`  in  1  data memory has completed the access.
- `dmem_error`  in  1  data memory address fault; sampled with `mem_ready`.
- `PC`  out  64  current instruction address.
- `phase`  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK, 6 PCUPD, 7 HALT.
- `f_en`, `d_en`, `e_en`, `m_en`, `w_en`  out  1 each  phase strobes; at most one is high in any cycle.
- `stat`  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS.
- `halted`  out  1  high in HALT.
- `instr_count`  out  32  number of retired instructions.

## Operation
- Reset values: `PC` = RESET_PC, `phase` = IDLE, `stat` = AOK (0), `instr_count` = 0, all strobes 0, `halted` = 0.
- IDLE -> FETCH when `start` = 1. Otherwise the controller stays in IDLE.
- FETCH asserts `f_en`, then moves to DECODE. The fetch outputs are valid from DECODE onward.
- DECODE asserts `d_en` and checks status, in this priority:
  - `imem_error` = 1: `stat` = ADR.
  - else `instr_valid` = 0: `stat` = INS.
  - else `icode` = 0: `stat` = HLT.
  - Any of these moves to HALT. Otherwise the controller moves to EXECUTE.
- EXECUTE asserts `e_en`, then moves to MEMORY.
- MEMORY asserts `m_en` for one cycle only, on entry.
  - Memory-op icodes (4, 5, 8, 9, 0xA, 0xB) wait until `mem_ready` = 1.
  - All other icodes leave MEMORY after exactly one cycle.
  - When `mem_ready` is sampled high with `dmem_error` = 1: `stat` = ADR, move to HALT.
  - After MEM_TIMEOUT cycles without `mem_ready`: `stat` = ADR, move to HALT.
- WRITEBACK asserts `w_en`, then moves to PCUPD.
- PCUPD updates PC and moves to FETCH:
  - `icode` 8 (call): PC <= valC.
  - `icode` 7 with `cnd` = 1: PC <= valC.
  - `icode` 9 (ret): PC <= valM.
  - All other cases: PC <= valP.
  - `instr_count` increments with wrap-around at 2^32.
- HALT is absorbing. Only `rst_n` exits it.
  - `PC` holds the faulting or halting instruction's address.
  - The halt instruction is not counted in `instr_count`.
- `start` is ignored outside IDLE.
- `icode`, `cnd` and `valM` are sampled only in the phases named above and are ignored in all other phases.

## Timing
- Minimum 6 cycles per instruction, FETCH through PCUPD.
- A memory-op instruction takes 5 + w cycles, where w is the number of MEMORY cycles (w >= 1).
- Strobes are registered outputs, high during the cycle in which `phase` shows their state.
- The new `PC` is visible in the cycle after PCUPD, which is the FETCH cycle of the next instruction.
- `stat` and `halted` change in the same edge as the entry to HALT.
- Reset mid-instruction: the next edge with `rst_n` = 0 forces all reset values, regardless of phase, pending memory wait or HALT.
- `rst_n` takes priority over `start` in the same cycle.

## Test plan
- Reset, then `start` with RESET_PC = 4 and a nop (icode 1, valP = 5): phases run 1,2,3,4,5,6,1. `PC` = 5 in the cycle after PCUPD. `instr_count` = 1.
- jXX: icode 7, valC = 0x40, valP = 0x0D. With `cnd` = 1, `PC` becomes 0x40. With `cnd` = 0, `PC` becomes 0x0D. Call (icode 8, valC = 0x100) gives `PC` = 0x100. Ret (icode 9, valM = 0x2A) gives `PC` = 0x2A.
- mrmovq (icode 5) with `mem_ready` delayed 3 cycles: MEMORY lasts 4 cycles and `m_en` pulses once. With `mem_ready` never asserted: after 15 cycles `stat` = 2 and `halted` = 1.
- DECODE checks:
  - icode 0: `stat` = 1, `halted` = 1, `PC` unchanged, count unchanged.
  - `instr_valid` = 0: `stat` = 3.
  - `imem_error` and `instr_valid` = 0 together: `stat` = 2, because ADR has priority.
- `rst_n` pulsed low during MEMORY wait, and again while in HALT: both return to IDLE with `PC` = RESET_PC and `stat` = 0. A subsequent `start` restarts execution.
- Strobe exclusivity: across 20 random instructions, at most one of `f_en`..`w_en` is high in any cycle.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// Phase sequencer and PC-update controller for the sequential Y86-64 core.
// Walks each instruction FETCH..PCUPD, owns the PC, and derives processor status.
module seq_stage_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic [2:0]  phase,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic [1:0]  stat,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        ST_AOK = 2'd0,
        ST_HLT = 2'd1,
        ST_ADR = 2'd2,
        ST_INS = 2'd3
    } stat_e;

    // Last MEMORY wait index before the access is declared lost.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    phase_e      state_q, state_d;
    stat_e       stat_q, stat_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  wait_q, wait_d;
    logic        f_en_q, d_en_q, e_en_q, m_en_q, w_en_q, halted_q;
    logic        is_memop;

    always_comb begin
        is_memop = 1'b0;
        case (icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_memop = 1'b1;
            default:                            is_memop = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        pc_d    = pc_q;
        count_d = count_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (imem_error) begin
                    stat_d  = ST_ADR;
                    state_d = S_HALT;
                end else if (!instr_valid) begin
                    stat_d  = ST_INS;
                    state_d = S_HALT;
                end else if (icode == 4'h0) begin
                    stat_d  = ST_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                wait_d  = '0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!is_memop) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_d  = ST_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    stat_d  = ST_ADR;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                if (icode == 4'h8 || (icode == 4'h7 && cnd)) begin
                    pc_d = valC;
                end else if (icode == 4'h9) begin
                    pc_d = valM;
                end else begin
                    pc_d = valP;
                end
                count_d = count_q + 32'd1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stat_q   <= ST_AOK;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wait_q   <= '0;
            f_en_q   <= 1'b0;
            d_en_q   <= 1'b0;
            e_en_q   <= 1'b0;
            m_en_q   <= 1'b0;
            w_en_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stat_q   <= stat_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            f_en_q   <= (state_d == S_FETCH);
            d_en_q   <= (state_d == S_DECODE);
            e_en_q   <= (state_d == S_EXECUTE);
            m_en_q   <= (state_d == S_MEMORY) && (state_q != S_MEMORY);
            w_en_q   <= (state_d == S_WRITEBACK);
            halted_q <= (state_d == S_HALT);
        end
    end

    assign PC          = pc_q;
    assign phase       = state_q;
    assign f_en        = f_en_q;
    assign d_en        = d_en_q;
    assign e_en        = e_en_q;
    assign m_en        = m_en_q;
    assign w_en        = w_en_q;
    assign stat        = stat_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
